data_mem_responder: RTL and testbench

Memory-side responder for the MEM stage of the five-stage pipeline: accepts one load/store request at a time from the datapath, models a data RAM with a configurable number of wait states, and returns read data with a one-cycle `Ready` pulse. While an access is outstanding, it drives `StallM` to the hazard unit, which freezes the pipeline. It replaces the zero-latency data memory wherever the design must tolerate a slower data store.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 28 ++
 rtl/data_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // Largest wait-state count the 4-bit wait counter can hold.
  localparam int WAIT_MAX = 15;

  // Number of word-index bits needed to address depth_words entries.
  function automatic int idx_width(input int depth_words);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth_words) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [IW-1:0] i_idx,
  input  logic [31:0]   i_wd,
  output logic [31:0]   o_rd
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wd[8*i +: 8];
      end
    end
  end

  assign o_rd = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder with configurable wait states.
// One access outstanding at a time; Ready pulses for one cycle on completion
// and StallM holds the pipeline while a request waits.
// Optional macro DMEM_ERR_CHECK_EN: flag misaligned / out-of-range accesses
// through Err (write suppressed, RD forced to 0). Without it, addresses wrap.
//
// state | meaning
// IDLE  | waiting for Req; inputs sampled here only
// BUSY  | counting down wait states
// DONE  | Ready/RD/Err valid for this single cycle
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [3:0]  BE,
  output logic [31:0] RD,
  output logic        Ready,
  output logic        StallM,
  output logic        Err
);

  localparam int         IW        = idx_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  dmem_state_e r_state, w_state_nxt;
  logic [3:0]  r_wcnt, w_wcnt_nxt;
  logic        w_accept;
  logic        w_enter_done;

  logic [31:0] r_addr, r_wd;
  logic        r_we;
  logic [3:0]  r_be;

  logic [31:0] r_rd;
  logic        r_ready;
  logic        r_err;

  logic [31:0] w_cur_addr, w_cur_wd;
  logic        w_cur_we;
  logic [3:0]  w_cur_be;
  logic [31:0] w_mem_rd;
  logic [31:0] w_merged;
  logic        w_fault;
  logic        w_ram_we;

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next-state logic; flags the edge that enters DONE.
  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_accept     = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Req) begin
          w_accept   = 1'b1;
          w_wcnt_nxt = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            w_state_nxt  = ST_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt == 4'd1) begin
          w_state_nxt  = ST_DONE;
          w_enter_done = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 32'd0;
      r_wd   <= 32'd0;
      r_we   <= 1'b0;
      r_be   <= 4'd0;
    end else if (w_accept) begin
      r_addr <= A;
      r_wd   <= WD;
      r_we   <= WE;
      r_be   <= BE;
    end
  end

  // With zero wait states IDLE goes straight to DONE, so the live inputs
  // must feed the array and checks on that edge instead of the latches.
  assign w_cur_addr = (r_state == ST_IDLE) ? A  : r_addr;
  assign w_cur_wd   = (r_state == ST_IDLE) ? WD : r_wd;
  assign w_cur_we   = (r_state == ST_IDLE) ? WE : r_we;
  assign w_cur_be   = (r_state == ST_IDLE) ? BE : r_be;

`ifdef DMEM_ERR_CHECK_EN
  logic w_misalign;
  logic w_out_of_range;
  assign w_misalign     = (w_cur_addr[1:0] != 2'b00) &&
                          (!w_cur_we || (w_cur_be == 4'hF));
  assign w_out_of_range = |w_cur_addr[31:IW+2];
  assign w_fault        = w_misalign | w_out_of_range;
`else
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{w_cur_addr[31:IW+2], w_cur_addr[1:0]};
  assign w_fault            = 1'b0;
`endif

  // A store reset away before DONE never reaches the array.
  assign w_ram_we = w_enter_done & w_cur_we & ~w_fault & ~reset;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_array (
    .clk  (clk),
    .i_we (w_ram_we),
    .i_be (w_cur_be),
    .i_idx(w_cur_addr[IW+1:2]),
    .i_wd (w_cur_wd),
    .o_rd (w_mem_rd)
  );

  // Post-write word, so a store returns what the array will hold after the edge.
  always_comb begin
    w_merged = w_mem_rd;
    for (int i = 0; i < 4; i++) begin
      if (w_cur_be[i]) w_merged[8*i +: 8] = w_cur_wd[8*i +: 8];
    end
  end

  // Registered response, valid only during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_enter_done;
      r_err   <= w_enter_done & w_fault;
      if (w_enter_done && !w_fault) r_rd <= w_cur_we ? w_merged : w_mem_rd;
      else                          r_rd <= 32'd0;
    end
  end

  assign RD     = r_rd;
  assign Ready  = r_ready;
  assign Err    = r_err;
  assign StallM = Req & ~r_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: instance 0 has zero wait states,
// instance 1 has two wait states; both are 256 words deep.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req    [2];
  logic [31:0] a      [2];
  logic [31:0] wd     [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] rd     [2];
  logic        ready  [2];
  logic        stallm [2];
  logic        err    [2];

  int n_assert = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .Req(req[0]), .A(a[0]), .WD(wd[0]), .WE(we[0]),
    .BE(be[0]), .RD(rd[0]), .Ready(ready[0]), .StallM(stallm[0]), .Err(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .Req(req[1]), .A(a[1]), .WD(wd[1]), .WE(we[1]),
    .BE(be[1]), .RD(rd[1]), .Ready(ready[1]), .StallM(stallm[1]), .Err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access on instance k; checks latency, stall count, RD and Err.
  task automatic access(input int k, input logic we_i, input logic [31:0] a_i,
                        input logic [31:0] wd_i, input logic [3:0] be_i,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
    int lat;
    int stalls;
    logic [31:0] got_rd;
    logic got_err;
    lat = -1; stalls = 0; got_rd = 32'hxxxxxxxx; got_err = 1'bx;
    req[k] = 1'b1; we[k] = we_i; a[k] = a_i; wd[k] = wd_i; be[k] = be_i;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stallm[k]) stalls++;
      if (ready[k]) begin
        lat = c; got_rd = rd[k]; got_err = err[k];
        break;
      end
    end
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
    chk({tag, "_rd"}, got_rd, exp_rd);
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
  endtask

  initial begin
    int pulses;
    int pulse_cyc;
    logic [31:0] pulse_rd;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; a[k] = 32'd0; wd[k] = 32'd0; we[k] = 1'b0; be[k] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_rd%0d", k),    rd[k],              32'd0);
      chk($sformatf("reset_ready%0d", k), {31'd0, ready[k]},  32'd0);
      chk($sformatf("reset_err%0d", k),   {31'd0, err[k]},    32'd0);
      chk($sformatf("reset_stall%0d", k), {31'd0, stallm[k]}, 32'd0);
    end
    reset = 1'b0;

    // Two wait states: full-word store then load back.
    access(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 32'hDEADBEEF, 1'b0, "st_10");
    access(1, 1'b0, 32'h10, 32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b0, "ld_10");

    // Byte-lane store.
    access(1, 1'b1, 32'h20, 32'h11223344, 4'hF,    3, 32'h11223344, 1'b0, "pre_20");
    access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3, 32'h11BB33DD, 1'b0, "st_lane");
    access(1, 1'b0, 32'h20, 32'h0,        4'h0,    3, 32'h11BB33DD, 1'b0, "ld_lane");

    // Reset during BUSY drops the in-flight store.
    access(1, 1'b1, 32'h30, 32'h55667788, 4'hF, 3, 32'h55667788, 1'b0, "pre_30");
    pulses = 0;
    req[1] = 1'b1; we[1] = 1'b1; a[1] = 32'h30; wd[1] = 32'hCAFEF00D; be[1] = 4'hF;
    @(negedge clk); if (ready[1]) pulses++;
    @(posedge clk); #1;
    reset = 1'b1; req[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk); if (ready[1]) pulses++;
    @(posedge clk); #1;
    @(negedge clk); if (ready[1]) pulses++;
    chk("rst_mid_rd",    rd[1],              32'd0);
    chk("rst_mid_err",   {31'd0, err[1]},    32'd0);
    chk("rst_mid_stall", {31'd0, stallm[1]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk); if (ready[1]) pulses++;
    end
    chk("rst_mid_pulses", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    access(1, 1'b0, 32'h30, 32'h0, 4'h0, 3, 32'h55667788, 1'b0, "ld_30_old");

    // Zero wait states: preload, then back-to-back loads.
    access(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 1, 32'h01020304, 1'b0, "ws0_st0");
    access(0, 1'b1, 32'h4, 32'h0A0B0C0D, 4'hF, 1, 32'h0A0B0C0D, 1'b0, "ws0_st4");
    req[0] = 1'b1; we[0] = 1'b0; a[0] = 32'h0; be[0] = 4'h0;
    @(negedge clk);
    chk("b2b_c0_ready", {31'd0, ready[0]},  32'd0);
    chk("b2b_c0_stall", {31'd0, stallm[0]}, 32'd1);
    @(posedge clk); #1;
    a[0] = 32'h4;
    @(negedge clk);
    chk("b2b_c1_ready", {31'd0, ready[0]},  32'd1);
    chk("b2b_c1_rd",    rd[0],              32'h01020304);
    chk("b2b_c1_stall", {31'd0, stallm[0]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_c2_ready", {31'd0, ready[0]},  32'd0);
    chk("b2b_c2_stall", {31'd0, stallm[0]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_c3_ready", {31'd0, ready[0]}, 32'd1);
    chk("b2b_c3_rd",    rd[0],             32'h0A0B0C0D);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_c4_ready", {31'd0, ready[0]}, 32'd0);
    @(posedge clk); #1;

    // Fault checking (misaligned and out-of-range accesses).
    access(1, 1'b1, 32'h0, 32'h13579BDF, 4'hF, 3, 32'h13579BDF, 1'b0, "pre_0");
`ifdef DMEM_ERR_CHECK_EN
    access(1, 1'b0, 32'h0000_0402, 32'h0,       4'h0, 3, 32'h0,        1'b1, "ld_402");
    access(1, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 3, 32'h0,        1'b1, "st_oor");
    access(1, 1'b0, 32'h0,         32'h0,       4'h0, 3, 32'h13579BDF, 1'b0, "ld_0_after");
`else
    access(1, 1'b0, 32'h0000_0402, 32'h0,       4'h0, 3, 32'h13579BDF, 1'b0, "ld_402");
    access(1, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 3, 32'hFFFFFFFF, 1'b0, "st_wrap");
    access(1, 1'b0, 32'h0,         32'h0,       4'h0, 3, 32'hFFFFFFFF, 1'b0, "ld_0_after");
`endif

    // Req dropped in cycle 1: the load still completes exactly once.
    pulses = 0; pulse_cyc = -1; pulse_rd = 32'h0;
    req[1] = 1'b1; we[1] = 1'b0; a[1] = 32'h10; be[1] = 4'h0;
    @(negedge clk); if (ready[1]) pulses++;
    @(posedge clk); #1;
    req[1] = 1'b0;
    for (int c = 1; c < 9; c++) begin
      @(negedge clk);
      if (ready[1]) begin
        pulses++; pulse_cyc = c; pulse_rd = rd[1];
      end
    end
    chk("drop_pulses", 32'(pulses),    32'd1);
    chk("drop_cycle",  32'(pulse_cyc), 32'd3);
    chk("drop_rd",     pulse_rd,       32'hDEADBEEF);
    @(posedge clk); #1;
    access(1, 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h11BB33DD, 1'b0, "after_drop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
